vec_mem_sequencer: RTL and testbench
====================================

# vec_mem_sequencer

Sequencer between the vector CPU's memory stage and the single-port, N-bit-wide data memory. It serializes one LANES-wide vector load or store into LANES scalar memory accesses at consecutive word addresses and stalls the CPU until the transfer completes. When the CPU is idle, it also grants the memory port to a secondary single-word readout port, such as the switch-driven display path.

## Interface
- N, 16, lane width in bits
- LANES, 16, lanes per vector; must be a power of two, ≥2
- AW, 32, memory word-address width
- CLK  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  vector access request; held high until cpu_done
- cpu_we  in  1  1 = vector store, 0 = vector load; sampled with cpu_req
- cpu_addr  in  AW  base word address; sampled with cpu_req
- cpu_wdata  in  LANES×N  store data, lane 0 is least significant; sampled with cpu_req
- cpu_stall  out  1  combinational: cpu_req & ~cpu_done
- cpu_done  out  1  one-cycle completion strobe
- cpu_rdata  out  LANES×N  load result; holds until the next load completes
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory word address
- mem_wdata  out  N  memory write data
- mem_rdata  in  N  memory read data; synchronous, valid the cycle after the address
- dbg_req  in  1  readout request, level
- dbg_addr  in  AW  readout word address; sampled at grant
- dbg_rdata  out  N  readout data register
- dbg_valid  out  1  one-cycle strobe when dbg_rdata updates

## Operation
- States: IDLE, WR, RD, RD_DRAIN, FIN, DBG, DBG_CAP.
- IDLE:
  - If cpu_req=1, latch cpu_we, cpu_addr and cpu_wdata, clear the lane counter, then go to WR or RD.
  - Else if dbg_req=1, latch dbg_addr and go to DBG.
  - The CPU has priority when both request in the same cycle.
- WR, one lane per cycle:
  - mem_we=1, mem_addr=base+cnt, mem_wdata=lane cnt of the latched data.
  - cnt increments each cycle. When cnt=LANES-1, go to FIN.
- RD:
  - mem_we=0, mem_addr=base+cnt.
  - From the second RD cycle onward, store mem_rdata into lane cnt-1 of the read buffer.
  - When cnt=LANES-1, go to RD_DRAIN.
- RD_DRAIN: capture mem_rdata into lane LANES-1. mem_addr holds its last value and mem_we=0. Go to FIN.
- FIN:
  - cpu_done=1, which drops cpu_stall.
  - For a load, copy the read buffer to cpu_rdata at the entry edge, so it is valid during FIN.
  - Return to IDLE. A cpu_req still high in the FIN cycle belongs to the finished transfer and is ignored. A new request is sampled in IDLE, earliest one cycle after FIN.
- DBG: mem_addr=latched dbg address, mem_we=0. Go to DBG_CAP.
- DBG_CAP: at the exit edge, dbg_rdata<=mem_rdata and dbg_valid<=1 for the next cycle. Return to IDLE.
  - A dbg_req still high re-arbitrates in IDLE.
  - A CPU request arriving during DBG/DBG_CAP waits at most 2 cycles.
- Address arithmetic is base+cnt modulo 2^AW; base near the top wraps to 0. cnt is log2(LANES) bits.
- In IDLE, FIN and DBG_CAP: mem_we=0 and mem_wdata=0. mem_addr holds its last value.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE, cnt=0, and the latched buffers clear.
  - cpu_done=0, cpu_rdata=0, dbg_rdata=0, dbg_valid=0.
  - mem_we=0, mem_addr=0, mem_wdata=0. mem_we must drop in the same cycle reset asserts.
- Reset mid-transfer abandons the transfer. Lanes already written stay in memory. No cpu_done is issued.
- Store latency, with the request sampled at edge 0:
  - WR occupies cycles 1..LANES.
  - FIN occurs in cycle LANES+1, which is 17 for the default parameters.
  - The CPU is stalled for LANES+1 cycles.
- Load latency:
  - RD occupies cycles 1..LANES and RD_DRAIN is cycle LANES+1.
  - FIN is cycle LANES+2, which is 18 for the default parameters.
- Readout latency: grant at edge 0, DBG in cycle 1, DBG_CAP in cycle 2, dbg_valid in cycle 3.
- cpu_stall is purely combinational from cpu_req and state. There is no registered path.

## Test plan
- Store: base=0x10, lane i = 0x1000+i → mem_we high exactly 16 cycles, mem_addr 0x10..0x1F, mem_wdata 0x1000..0x100F, cpu_done in cycle 17, cpu_stall low only in the FIN cycle.
- Load after store, same base → cpu_rdata lane i = 0x1000+i in cycle 18. cpu_rdata unchanged through a following store.
- Wrap: base=0xFFFF_FFFE store → addresses 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0, …, 0xD.
- Arbitration: cpu_req and dbg_req rise together → CPU served first, DBG granted in the IDLE after FIN. A CPU request raised in the DBG cycle → WR starts in cycle 3.
- Readout: dbg_addr=0x12 after the store → dbg_valid one cycle with dbg_rdata=0x1002.
- Reset asserted in WR lane 5 → mem_we=0 immediately, no cpu_done, all outputs 0. After release, a fresh store completes normally.

Source files
------------

// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer
//
// Serializes one LANES-wide vector load or store from the vector CPU into
// LANES scalar accesses on a single-port, N-bit data memory at consecutive
// word addresses (base+0 .. base+LANES-1, wrapping modulo 2^AW). While the
// CPU is idle the memory port is lent to a single-word readout path.
//
// Ports
//   CLK, reset            rising-edge clock, asynchronous active-high reset
//   cpu_req/cpu_we        vector request (level, held until cpu_done) / 1=store
//   cpu_addr/cpu_wdata    base word address / store data (lane 0 = LSBs)
//   cpu_stall             cpu_req & ~cpu_done, purely combinational
//   cpu_done              one-cycle completion strobe (the FIN state)
//   cpu_rdata             load result, held until the next load completes
//   mem_we/addr/wdata     memory port; mem_rdata arrives the cycle after addr
//   dbg_req/dbg_addr      readout request (level) / address sampled at grant
//   dbg_rdata/dbg_valid   readout data register / one-cycle update strobe
//   fsm_state             current FSM state, for observation only
//
// Handshake: the CPU raises cpu_req with cpu_we/cpu_addr/cpu_wdata valid and
// keeps it high until it sees cpu_done; the operands are captured in IDLE and
// not looked at again. A cpu_req still high during FIN belongs to the finished
// transfer; a new request is taken in IDLE at the earliest one cycle after FIN.
// dbg_req is a level; each grant produces exactly one dbg_valid pulse, and a
// request still high afterwards is simply re-arbitrated in IDLE (CPU first).
module vec_mem_sequencer #(
  parameter int N     = 16,
  parameter int LANES = 16,
  parameter int AW    = 32
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [LANES*N-1:0]   cpu_wdata,
  output logic                 cpu_stall,
  output logic                 cpu_done,
  output logic [LANES*N-1:0]   cpu_rdata,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [N-1:0]         mem_wdata,
  input  logic [N-1:0]         mem_rdata,
  input  logic                 dbg_req,
  input  logic [AW-1:0]        dbg_addr,
  output logic [N-1:0]         dbg_rdata,
  output logic                 dbg_valid,
  output logic [2:0]           fsm_state
);

  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD       = 3'd2,
    RD_DRAIN = 3'd3,
    FIN      = 3'd4,
    DBG      = 3'd5,
    DBG_CAP  = 3'd6
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cnt;
  logic [AW-1:0]        base;
  logic [AW-1:0]        dbg_base;
  logic [AW-1:0]        addr_hold;
  logic [AW-1:0]        lane_addr;
  logic [LANES*N-1:0]   wbuf;
  logic [LANES*N-1:0]   rbuf;
  logic [LANES*N-1:0]   drain_vec;
  logic [LANES*N-1:0]   rdata_q;
  logic [N-1:0]         dbg_rdata_q;
  logic                 dbg_valid_q;

  // AW-bit addition wraps naturally past the top of the address space.
  assign lane_addr = base + AW'(cnt);

  // Read buffer with the final lane taken straight from the memory, so the
  // completed vector can be loaded into cpu_rdata on the edge entering FIN.
  always_comb begin
    drain_vec = rbuf;
    drain_vec[(LANES-1)*N +: N] = mem_rdata;
  end

  // State register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          state_nxt = cpu_we ? WR : RD;
        end else if (dbg_req) begin
          state_nxt = DBG;
        end
      end
      WR:       if (cnt == LAST) state_nxt = FIN;
      RD:       if (cnt == LAST) state_nxt = RD_DRAIN;
      RD_DRAIN: state_nxt = FIN;
      FIN:      state_nxt = IDLE;
      DBG:      state_nxt = DBG_CAP;
      DBG_CAP:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Memory port outputs are decoded from the state so that an asynchronous
  // reset drops mem_we in the same cycle. Outside WR/RD/DBG the address holds
  // the last value driven (0 after reset).
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_addr  = addr_hold;
    case (state)
      WR: begin
        mem_we    = 1'b1;
        mem_addr  = lane_addr;
        mem_wdata = wbuf[int'(cnt)*N +: N];
      end
      RD:      mem_addr = lane_addr;
      DBG:     mem_addr = dbg_base;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      base        <= '0;
      dbg_base    <= '0;
      addr_hold   <= '0;
      wbuf        <= '0;
      rbuf        <= '0;
      rdata_q     <= '0;
      dbg_rdata_q <= '0;
      dbg_valid_q <= 1'b0;
    end else begin
      addr_hold   <= mem_addr;
      dbg_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            base <= cpu_addr;
            wbuf <= cpu_wdata;
            cnt  <= '0;
          end else if (dbg_req) begin
            dbg_base <= dbg_addr;
          end
        end
        WR: cnt <= cnt + CW'(1);
        RD: begin
          // Data for the address issued last cycle belongs to lane cnt-1.
          if (cnt != '0) begin
            rbuf[(int'(cnt)-1)*N +: N] <= mem_rdata;
          end
          cnt <= cnt + CW'(1);
        end
        RD_DRAIN: begin
          rbuf    <= drain_vec;
          rdata_q <= drain_vec;
        end
        DBG_CAP: begin
          dbg_rdata_q <= mem_rdata;
          dbg_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cpu_done  = (state == FIN);
  assign cpu_stall = cpu_req & ~cpu_done;
  assign cpu_rdata = rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign dbg_valid = dbg_valid_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Bench for vec_mem_sequencer: a behavioural synchronous-read memory, driver
// tasks for vector stores/loads and readouts, and a monitor that pops the
// expected queues whenever the DUT writes memory, strobes cpu_done or
// strobes dbg_valid.
module tb_vec_mem_sequencer;
  localparam int N     = 16;
  localparam int LANES = 16;
  localparam int AW    = 32;
  localparam int VW    = N * LANES;

  logic            CLK;
  logic            reset;
  logic            cpu_req;
  logic            cpu_we;
  logic [AW-1:0]   cpu_addr;
  logic [VW-1:0]   cpu_wdata;
  logic            cpu_stall;
  logic            cpu_done;
  logic [VW-1:0]   cpu_rdata;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [N-1:0]    mem_wdata;
  logic [N-1:0]    mem_rdata;
  logic            dbg_req;
  logic [AW-1:0]   dbg_addr;
  logic [N-1:0]    dbg_rdata;
  logic            dbg_valid;
  logic [2:0]      fsm_state;

  vec_mem_sequencer #(.N(N), .LANES(LANES), .AW(AW)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_stall (cpu_stall),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata),
    .dbg_valid (dbg_valid),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- memory model ----------------
  logic [N-1:0] mem [logic [AW-1:0]];
  always @(posedge CLK) begin
    logic [N-1:0] rd;
    rd = mem.exists(mem_addr) ? mem[mem_addr] : '0;
    if (mem_we) mem[mem_addr] = mem_wdata;
    mem_rdata <= rd;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [AW+N-1:0] wr_q[$];
  logic [VW-1:0]   done_q[$];
  logic [N-1:0]    dbg_q[$];
  logic [VW-1:0]   last_rd = '0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [VW-1:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected no event", name, act);
  endtask

  always @(negedge CLK) begin
    if (!reset) begin
      if (mem_we) begin
        if (wr_q.size() == 0) flag("unexpected_mem_write", VW'({mem_addr, mem_wdata}));
        else check("mem_write", VW'({mem_addr, mem_wdata}), VW'(wr_q.pop_front()));
      end
      if (cpu_done) begin
        if (done_q.size() == 0) flag("unexpected_cpu_done", cpu_rdata);
        else check("cpu_rdata_at_done", cpu_rdata, done_q.pop_front());
      end
      if (dbg_valid) begin
        if (dbg_q.size() == 0) flag("unexpected_dbg_valid", VW'(dbg_rdata));
        else check("dbg_rdata", VW'(dbg_rdata), VW'(dbg_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks are entered at a negedge with the DUT in IDLE (or DBG for the
  // preempted store). pre = cycles the store is expected to wait behind a
  // readout already in progress.
  task automatic do_store(input logic [AW-1:0] base, input logic [N-1:0] seed,
                          input int pre, input string tag);
    logic [VW-1:0] vec;
    int stall_cnt, we_cnt, first_we, done_at;
    for (int i = 0; i < LANES; i++) begin
      vec[i*N +: N] = seed + N'(i);
      wr_q.push_back({base + AW'(i), seed + N'(i)});
    end
    done_q.push_back(last_rd);
    cpu_we = 1'b1; cpu_addr = base; cpu_wdata = vec; cpu_req = 1'b1;
    #1;
    stall_cnt = cpu_stall ? 1 : 0;
    we_cnt = 0; first_we = -1; done_at = -1;
    for (int c = 1; c <= 100 && done_at < 0; c++) begin
      @(negedge CLK);
      if (mem_we) begin
        we_cnt++;
        if (first_we < 0) first_we = c;
      end
      if (cpu_stall) stall_cnt++;
      if (cpu_done) done_at = c;
    end
    cpu_req = 1'b0;
    if (done_at < 0) flag({tag, "_done_timeout"}, '0);
    check({tag, "_done_cycle"}, VW'(done_at), VW'(LANES + 1 + pre));
    check({tag, "_we_cycles"}, VW'(we_cnt), VW'(LANES));
    check({tag, "_first_we_cycle"}, VW'(first_we), VW'(1 + pre));
    check({tag, "_stall_cycles"}, VW'(stall_cnt), VW'(LANES + 1 + pre));
    @(negedge CLK);
  endtask

  task automatic do_load(input logic [AW-1:0] base, input logic [N-1:0] seed, input string tag);
    logic [VW-1:0] exp;
    int stall_cnt, we_cnt, done_at;
    for (int i = 0; i < LANES; i++) exp[i*N +: N] = seed + N'(i);
    done_q.push_back(exp);
    last_rd = exp;
    cpu_we = 1'b0; cpu_addr = base; cpu_wdata = '0; cpu_req = 1'b1;
    #1;
    stall_cnt = cpu_stall ? 1 : 0;
    we_cnt = 0; done_at = -1;
    for (int c = 1; c <= 100 && done_at < 0; c++) begin
      @(negedge CLK);
      if (mem_we) we_cnt++;
      if (cpu_stall) stall_cnt++;
      if (cpu_done) done_at = c;
    end
    cpu_req = 1'b0;
    if (done_at < 0) flag({tag, "_done_timeout"}, '0);
    check({tag, "_done_cycle"}, VW'(done_at), VW'(LANES + 2));
    check({tag, "_we_cycles"}, VW'(we_cnt), VW'(0));
    check({tag, "_stall_cycles"}, VW'(stall_cnt), VW'(LANES + 2));
    @(negedge CLK);
  endtask

  task automatic do_dbg(input logic [AW-1:0] addr, input logic [N-1:0] exp,
                        input int exp_lat, input string tag);
    int lat;
    dbg_q.push_back(exp);
    dbg_addr = addr; dbg_req = 1'b1;
    lat = -1;
    for (int c = 1; c <= 100 && lat < 0; c++) begin
      @(negedge CLK);
      if (dbg_valid) lat = c;
    end
    dbg_req = 1'b0;
    if (lat < 0) flag({tag, "_valid_timeout"}, '0);
    check({tag, "_valid_cycle"}, VW'(lat), VW'(exp_lat));
    @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_we"}, VW'(mem_we), VW'(0));
    check({tag, "_mem_addr"}, VW'(mem_addr), VW'(0));
    check({tag, "_mem_wdata"}, VW'(mem_wdata), VW'(0));
    check({tag, "_cpu_done"}, VW'(cpu_done), VW'(0));
    check({tag, "_cpu_rdata"}, cpu_rdata, VW'(0));
    check({tag, "_dbg_rdata"}, VW'(dbg_rdata), VW'(0));
    check({tag, "_dbg_valid"}, VW'(dbg_valid), VW'(0));
    check({tag, "_fsm_state"}, VW'(fsm_state), VW'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_addr = '0;
    reset = 1'b1;
    @(negedge CLK);
    check_reset_outputs("por");
    check("por_cpu_stall", VW'(cpu_stall), VW'(0));
    reset = 1'b0;
    repeat (2) @(negedge CLK);

    // Store at 0x10 with a readout raised in the same cycle: the CPU wins and
    // the readout (of a lane just written) is granted in the IDLE after FIN.
    fork
      do_store(32'h10, 16'h1000, 0, "store_10");
      do_dbg(32'h12, 16'h1002, 21, "dbg_behind_store");
    join
    do_dbg(32'h12, 16'h1002, 3, "dbg_12");
    do_load(32'h10, 16'h1000, "load_10");
    do_store(32'h20, 16'h5000, 0, "store_20_rdata_held");

    // Address wrap at the top of the address space.
    do_store(32'hFFFF_FFFE, 16'h2000, 0, "store_wrap");
    do_dbg(32'h0, 16'h2002, 3, "dbg_wrap_0");
    do_dbg(32'hFFFF_FFFF, 16'h2001, 3, "dbg_wrap_top");
    do_load(32'hFFFF_FFFE, 16'h2000, "load_wrap");

    // CPU request raised while a readout is in its DBG cycle.
    fork
      do_dbg(32'h1F, 16'h100F, 3, "dbg_preempt");
      begin
        @(negedge CLK);
        do_store(32'h30, 16'h7000, 2, "store_after_dbg");
      end
    join
    do_load(32'h30, 16'h7000, "load_30");

    // Reset during WR lane 5: lanes 0..5 are presented, lane 5 never commits.
    for (int i = 0; i < 6; i++) wr_q.push_back({32'h40 + AW'(i), 16'h3000 + N'(i)});
    cpu_we = 1'b1; cpu_addr = 32'h40; cpu_req = 1'b1;
    for (int i = 0; i < LANES; i++) cpu_wdata[i*N +: N] = 16'h3000 + N'(i);
    repeat (6) @(negedge CLK);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    check("mid_reset_wr_q_drained", VW'(wr_q.size()), VW'(0));
    cpu_req = 1'b0;
    last_rd = '0;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    do_dbg(32'h44, 16'h3004, 3, "dbg_kept_lane4");
    do_store(32'h40, 16'h6000, 0, "store_after_reset");
    do_load(32'h40, 16'h6000, "load_after_reset");

    repeat (4) @(negedge CLK);
    check("end_wr_q_empty", VW'(wr_q.size()), VW'(0));
    check("end_done_q_empty", VW'(done_q.size()), VW'(0));
    check("end_dbg_q_empty", VW'(dbg_q.size()), VW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
